// File: rtl/can_rx_pkg.sv
// Shared definitions for the CAN receive frame assembler: FSM encoding,
// receive-buffer address map, identifier lengths and the DLC clamp.
package can_rx_pkg;

    typedef enum logic [3:0] {
        IDLE,
        BASE_ID,
        SRR_IDE,
        EXT_ID,
        CTRL,
        DLC,
        DATA,
        WAIT_END,
        COMMIT
    } rx_state_t;

    localparam int ADR_INFO     = 0;
    localparam int ADR_ID0      = 1;
    localparam int ADR_DATA_STD = 3;
    localparam int ADR_DATA_EXT = 5;

    localparam int STD_ID_LEN = 11;
    localparam int EXT_ID_LEN = 18;

    // DLC codes 9..15 still mean "max bytes" on the wire
    function automatic logic [3:0] clamp_dlc(input logic [3:0] dlc, input logic [3:0] max_bytes);
        return (dlc > max_bytes) ? max_bytes : dlc;
    endfunction

endpackage

// File: rtl/can_rx_assembler_shifter.sv
// Byte packer: 8-bit MSB-first shift register and bit counter. o_next and
// o_byte_ready look ahead at the incoming bit so the caller can write the byte
// on the same edge that shifts it in.
module can_rx_shifter (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       i_clear,
    input  logic       i_shift,
    input  logic       i_bit,
    output logic [7:0] o_data,
    output logic [7:0] o_next,
    output logic       o_byte_ready
);

    logic [7:0] r_data;
    logic [2:0] r_cnt;

    assign o_data       = r_data;
    assign o_next       = {r_data[6:0], i_bit};
    assign o_byte_ready = i_shift && !i_clear && (r_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_clear) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_data <= o_next;
            r_cnt  <= r_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/can_rx_assembler.sv
// CAN receive frame assembler: packs ID/RTR/IDE/DLC/data into the 13-byte
// receive buffer. Optional acceptance filter: define CAN_RX_ACC_FILTER_EN.
module can_rx_assembler
    import can_rx_pkg::*;
#(
    parameter int MAX_DATA = 8,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst_b,
`ifdef CAN_RX_ACC_FILTER_EN
    input  logic [7:0]        acc_code,
    input  logic [7:0]        acc_mask,
`endif
    input  logic              frame_start,
    input  logic              bit_valid,
    input  logic              bit_val,
    input  logic              frame_ok,
    input  logic              frame_err,
    input  logic              buf_free,
    output logic              buf_we_b,
    output logic [ADDR_W-1:0] buf_adress,
    output logic [7:0]        buf_datain,
    output logic              rx_done,
    output logic              overrun,
    output logic              rx_busy
);

    rx_state_t         r_state, w_state_next;
    logic [6:0]        r_cnt, w_cnt_next;
    logic [6:0]        r_nbits, w_nbits_next;
    logic [3:0]        r_dlc, w_dlc_next;
    logic              r_rtr, w_rtr_next;
    logic              r_ide, w_ide_next;
    logic              r_drop, w_drop_next;
    logic              r_rej, w_rej_next;
    logic [ADDR_W-1:0] r_ptr, w_ptr_next;
    logic              r_we_b, w_we_b_next;
    logic [ADDR_W-1:0] r_adr, w_adr_next;
    logic [7:0]        r_dat, w_dat_next;
    logic              r_done, w_done_next;
    logic              r_ovr, w_ovr_next;

    logic       w_sh_clr, w_sh_en, w_byte_ready, w_wr, w_trunc;
    logic [7:0] w_sh_data, w_sh_next, w_wr_dat;
    logic [3:0] w_dlc_shift, w_dlc_clamp;

    can_rx_shifter u_shifter (
        .clk          (clk),
        .rst_b        (rst_b),
        .i_clear      (w_sh_clr),
        .i_shift      (w_sh_en),
        .i_bit        (bit_val),
        .o_data       (w_sh_data),
        .o_next       (w_sh_next),
        .o_byte_ready (w_byte_ready)
    );

    assign w_dlc_shift = {r_dlc[2:0], bit_val};
    assign w_dlc_clamp = clamp_dlc(w_dlc_shift, 4'(MAX_DATA));
    // An EOF arriving before the data field is complete is a broken frame
    assign w_trunc = frame_ok && (r_state != IDLE) && (r_state != WAIT_END) && (r_state != COMMIT);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_nbits_next = r_nbits;
        w_dlc_next   = r_dlc;
        w_rtr_next   = r_rtr;
        w_ide_next   = r_ide;
        w_drop_next  = r_drop;
        w_rej_next   = r_rej;
        w_ptr_next   = r_ptr;
        w_we_b_next  = 1'b1;
        w_adr_next   = r_adr;
        w_dat_next   = r_dat;
        w_done_next  = 1'b0;
        w_ovr_next   = 1'b0;
        w_sh_clr     = 1'b0;
        w_sh_en      = 1'b0;
        w_wr         = 1'b0;
        w_wr_dat     = '0;

        if (frame_err) begin
            w_state_next = IDLE;
        end else if (frame_start) begin
            w_state_next = BASE_ID;
            w_cnt_next   = '0;
            w_rtr_next   = 1'b0;
            w_ide_next   = 1'b0;
            w_dlc_next   = '0;
            w_drop_next  = !buf_free;
            w_rej_next   = 1'b0;
            w_ptr_next   = ADDR_W'(ADR_ID0);
            w_sh_clr     = 1'b1;
        end else if (w_trunc) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                WAIT_END: if (frame_ok) begin
                    if (r_rej) begin
                        w_state_next = IDLE;
                    end else if (r_drop) begin
                        w_ovr_next   = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_we_b_next  = 1'b0;
                        w_adr_next   = ADDR_W'(ADR_INFO);
                        w_dat_next   = {r_ide, r_rtr, 2'b00, r_dlc};
                        w_state_next = COMMIT;
                    end
                end
                COMMIT: begin
                    w_done_next  = 1'b1;
                    w_state_next = IDLE;
                end
                BASE_ID: if (bit_valid) begin
                    w_sh_en  = 1'b1;
                    w_wr     = w_byte_ready;
                    w_wr_dat = w_sh_next;
`ifdef CAN_RX_ACC_FILTER_EN
                    if (r_cnt == 7'd7 && ((w_sh_next ^ acc_code) & ~acc_mask) != 8'd0)
                        w_rej_next = 1'b1;
`endif
                    if (r_cnt == 7'(STD_ID_LEN - 1)) begin
                        w_cnt_next   = '0;
                        w_state_next = SRR_IDE;
                    end else begin
                        w_cnt_next = r_cnt + 7'd1;
                    end
                end
                SRR_IDE: if (bit_valid) begin
                    if (r_cnt == 7'd0) begin
                        w_rtr_next = bit_val;
                        w_cnt_next = 7'd1;
                    end else begin
                        w_ide_next = bit_val;
                        w_cnt_next = '0;
                        if (bit_val) begin
                            w_state_next = EXT_ID;
                        end else begin
                            // left-justify the 3 leftover ID bits
                            w_wr         = 1'b1;
                            w_wr_dat     = w_sh_data << 5;
                            w_state_next = CTRL;
                        end
                    end
                end
                EXT_ID: if (bit_valid) begin
                    w_sh_en  = 1'b1;
                    w_wr     = w_byte_ready;
                    w_wr_dat = w_sh_next;
                    if (r_cnt == 7'(EXT_ID_LEN - 1)) begin
                        w_wr         = 1'b1;
                        w_wr_dat     = w_sh_next << 3;
                        w_cnt_next   = '0;
                        w_state_next = CTRL;
                    end else begin
                        w_cnt_next = r_cnt + 7'd1;
                    end
                end
                CTRL: if (bit_valid) begin
                    if (r_ide && r_cnt == 7'd0)
                        w_rtr_next = bit_val;
                    if (r_cnt == (r_ide ? 7'd2 : 7'd0)) begin
                        w_cnt_next   = '0;
                        w_state_next = DLC;
                    end else begin
                        w_cnt_next = r_cnt + 7'd1;
                    end
                end
                DLC: if (bit_valid) begin
                    w_dlc_next = w_dlc_shift;
                    if (r_cnt == 7'd3) begin
                        w_cnt_next = '0;
                        if (!r_rtr && w_dlc_shift != 4'd0) begin
                            w_nbits_next = {w_dlc_clamp, 3'b000};
                            w_ptr_next   = r_ide ? ADDR_W'(ADR_DATA_EXT) : ADDR_W'(ADR_DATA_STD);
                            w_sh_clr     = 1'b1;
                            w_state_next = DATA;
                        end else begin
                            w_state_next = WAIT_END;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 7'd1;
                    end
                end
                DATA: if (bit_valid) begin
                    w_sh_en    = 1'b1;
                    w_wr       = w_byte_ready;
                    w_wr_dat   = w_sh_next;
                    w_cnt_next = r_cnt + 7'd1;
                    if (r_cnt == r_nbits - 7'd1)
                        w_state_next = WAIT_END;
                end
                default: ;
            endcase

            if (w_wr) begin
                w_ptr_next = r_ptr + ADDR_W'(1);
                if (!r_drop && !w_rej_next) begin
                    w_we_b_next = 1'b0;
                    w_adr_next  = r_ptr;
                    w_dat_next  = w_wr_dat;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_nbits <= '0;
            r_dlc   <= '0;
            r_rtr   <= 1'b0;
            r_ide   <= 1'b0;
            r_drop  <= 1'b0;
            r_rej   <= 1'b0;
            r_ptr   <= '0;
            r_we_b  <= 1'b1;
            r_adr   <= '0;
            r_dat   <= '0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_nbits <= w_nbits_next;
            r_dlc   <= w_dlc_next;
            r_rtr   <= w_rtr_next;
            r_ide   <= w_ide_next;
            r_drop  <= w_drop_next;
            r_rej   <= w_rej_next;
            r_ptr   <= w_ptr_next;
            r_we_b  <= w_we_b_next;
            r_adr   <= w_adr_next;
            r_dat   <= w_dat_next;
            r_done  <= w_done_next;
            r_ovr   <= w_ovr_next;
        end
    end

    assign buf_we_b   = r_we_b;
    assign buf_adress = r_adr;
    assign buf_datain = r_dat;
    assign rx_done    = r_done;
    assign overrun    = r_ovr;
    assign rx_busy    = (r_state != IDLE);

endmodule
